// File: rtl/fpmul_resp_checker_pkg.sv
// fp_tb_pkg: float field constants, NaN test and checker FSM encoding
package fp_tb_pkg;
    localparam int NB = 32;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MAN_W = 23;
    localparam int DRN_W = 5;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    function automatic logic is_nan(input logic [NB-1:0] x);
        return (&x[EXP_MSB:EXP_LSB]) && (|x[MAN_W-1:0]);
    endfunction
endpackage

// File: rtl/fpmul_resp_checker_if.sv
// fpmul_resp_checker_if: stimulus-side inputs and checker status outputs
interface fpmul_resp_checker_if #(
    parameter int Nb = fp_tb_pkg::NB,
    parameter int CNT_W = 16
);
    logic EN;
    logic EOF;
    logic [Nb-1:0] EXP_Z;
    logic [Nb-1:0] DUT_Z;
    logic MISMATCH;
    logic [CNT_W-1:0] CHK_CNT;
    logic [CNT_W-1:0] ERR_CNT;
    logic END_SIM;
    logic PASS;
    modport master (output EN, EOF, EXP_Z, DUT_Z, input MISMATCH, CHK_CNT, ERR_CNT, END_SIM, PASS);
    modport slave (input EN, EOF, EXP_Z, DUT_Z, output MISMATCH, CHK_CNT, ERR_CNT, END_SIM, PASS);
endinterface

// File: rtl/fpmul_resp_checker_valid_delay_line.sv
// valid_delay_line: fixed-depth shift register of {valid, data}, no stall
module valid_delay_line #(
    parameter int W = 32,
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic in_v,
    input  logic [W-1:0] in_d,
    output logic out_v,
    output logic [W-1:0] out_d
);
    logic [DEPTH-1:0] v;
    logic [W-1:0] d [DEPTH];
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v <= '0;
        end else begin
            v[0] <= in_v;
            for (int i = 1; i < DEPTH; i++) v[i] <= v[i-1];
        end
    end
    // Data needs no reset: it is only observed when its valid bit is set
    always_ff @(posedge CLK) begin
        d[0] <= in_d;
        for (int i = 1; i < DEPTH; i++) d[i] <= d[i-1];
    end
    assign out_v = v[DEPTH-1];
    assign out_d = d[DEPTH-1];
endmodule

// File: rtl/fpmul_resp_checker.sv
// fpmul_resp_checker: delays golden products by the DUT latency, compares, counts, signals end
module fpmul_resp_checker
    import fp_tb_pkg::*;
#(
    parameter int Nb = NB,
    parameter int LATENCY = 4,
    parameter int CNT_W = 16,
    parameter int NAN_EQ = 1
) (
    input logic CLK,
    input logic RST,
    fpmul_resp_checker_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state;
    logic [DRN_W-1:0] drn;
    logic issue, dl_v, equal, mismatch, end_sim;
    logic [Nb-1:0] dl_d;
    logic [CNT_W-1:0] chk_cnt, err_cnt;
    assign issue = bus.EN && !bus.EOF && (state == IDLE || state == RUN);
    // An X on DUT_Z makes equal X, which takes the mismatch branch below
    assign equal = (dl_d == bus.DUT_Z) || (NAN_EQ != 0 && is_nan(dl_d) && is_nan(bus.DUT_Z));
    valid_delay_line #(.W(Nb), .DEPTH(LATENCY)) u_dl (
        .CLK(CLK), .RST(RST), .in_v(issue), .in_d(bus.EXP_Z), .out_v(dl_v), .out_d(dl_d)
    );
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            drn <= '0;
            mismatch <= 1'b0;
            chk_cnt <= '0;
            err_cnt <= '0;
            end_sim <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (dl_v) begin
                if (chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + 1'b1;
                if (equal) mismatch <= 1'b0;
                else begin
                    mismatch <= 1'b1;
                    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                end
            end
            case (state)
                IDLE, RUN: begin
                    if (bus.EN && bus.EOF) begin
                        state <= DRAIN;
                        drn <= DRN_W'(LATENCY);
                    end else if (issue) state <= RUN;
                end
                DRAIN: begin
                    drn <= drn - 1'b1;
                    if (drn == DRN_W'(1)) begin
                        state <= DONE;
                        end_sim <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.MISMATCH = mismatch;
    assign bus.CHK_CNT = chk_cnt;
    assign bus.ERR_CNT = err_cnt;
    assign bus.END_SIM = end_sim;
    assign bus.PASS = end_sim && (err_cnt == '0);
endmodule

// File: doc/fpmul_resp_checker.md
Name: fpmul_resp_checker

Overview:
- Response-side counterpart to the stimulus path of the FPmul pipeline bench.
- Takes golden expected products, issued in step with the stimulus samples, and delays them by the DUT pipeline latency.
- Compares the delayed values bit-exactly against FP_Z, counts checks and errors, then raises END_SIM after the pipeline drains following EOF.
- Synthesizable, so it can also sit beside the DUT in a self-checking wrapper.

Parameters:
- Nb, 32, data width of expected and DUT words.
- LATENCY, 4, DUT pipeline depth in clock cycles; legal range 1..16.
- CNT_W, 16, width of the check and error counters.
- NAN_EQ, 1, when 1 any two NaNs compare equal (exp=0xFF, mantissa!=0); when 0 comparison is bitwise.

Ports:
- CLK  in  1  bench clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  sample-issue enable (same signal that enables the stimulus generator).
- EOF  in  1  end-of-file from the stimulus generator; the sample on an EOF cycle is not issued.
- EXP_Z  in  Nb  golden product for the sample issued this cycle.
- DUT_Z  in  Nb  FPmul FP_Z output.
- MISMATCH  out  1  one-cycle pulse when a compared pair differs.
- CHK_CNT  out  CNT_W  number of compares performed.
- ERR_CNT  out  CNT_W  number of mismatches.
- END_SIM  out  1  level; high once draining is complete.
- PASS  out  1  valid while END_SIM=1; equals (ERR_CNT==0).

Behaviour:
- Reset (RST=1, asynchronous):
  - MISMATCH=0, CHK_CNT=0, ERR_CNT=0, END_SIM=0, PASS=0.
  - All delay-line valid bits cleared; FSM goes to IDLE.
  - Reset mid-run discards all in-flight entries with no compare.
- Issue condition: issue = EN & ~EOF & (state==IDLE or RUN).
- Delay line: LATENCY stages, each {valid, data}.
  - Stage0 loads {issue, EXP_Z} every cycle.
  - Stage k loads stage k-1 every cycle; there is no stall.
  - Cycles with EN=0 insert bubbles (valid=0).
- Compare slot: the last stage is compared with DUT_Z combinationally.
  - An expected value issued at edge t is compared against DUT_Z sampled at edge t+LATENCY.
  - If the last stage is valid: CHK_CNT+1 at that edge; on mismatch ERR_CNT+1 and MISMATCH=1 for the following cycle.
  - If the last stage is invalid: nothing happens and MISMATCH=0.
- Counters saturate at 2^CNT_W-1 and never wrap. The error counter still saturates independently.
- FSM states:
  - IDLE: wait for issue; on the first issue go to RUN.
  - RUN: on EOF=1 (EN=1) go to DRAIN and load drain counter = LATENCY.
  - DRAIN: no new issues; decrement the drain counter each cycle; at 0 go to DONE.
  - DONE: END_SIM=1, PASS=(ERR_CNT==0). DONE is absorbing until RST.
- EOF in IDLE (empty file): go directly to DONE after LATENCY cycles via DRAIN; CHK_CNT=0, PASS=1.
- EN low while EOF high: EOF is ignored until EN=1, matching the generator's behaviour.
- The last valid compare and END_SIM never occur in the same cycle; END_SIM rises the cycle after the final compare edge.
- X on DUT_Z at a valid compare counts as a mismatch: a bitwise compare with X is not true.

Decomposition:
- Shared package (fp_tb_pkg): Nb default, the float field constants (EXP_MSB=30, EXP_LSB=23, MAN_W=23), the is_nan function, and the FSM state encoding (IDLE, RUN, DRAIN, DONE).
- One natural sub-module: valid_delay_line (parameters W and DEPTH; ports CLK, RST, in_v, in_d, out_v, out_d).
- The checker instantiates valid_delay_line with W=Nb, DEPTH=LATENCY; the compare, counters and FSM live in the top.

Test Plan:
- Happy path: LATENCY=4, issue 8 samples with EXP_Z=DUT_Z model (3F800000 -> 3F800000 after 4 cycles), EOF on cycle 9. Required: CHK_CNT=8, ERR_CNT=0, END_SIM rises exactly 4 cycles after the EOF edge, PASS=1.
- Single error: corrupt DUT_Z on the 3rd compare (expected 40800000, DUT 40800001). Required: one MISMATCH pulse on that cycle+1, ERR_CNT=1, PASS=0 at END.
- Bubbles: EN toggles 1,0,1,0 over 6 samples. Required: compares occur only LATENCY cycles after each EN=1 edge, CHK_CNT=6, no MISMATCH on bubble cycles even with DUT_Z=FFFFFFFF.
- NaN handling: EXP_Z=7FC00000, DUT_Z=7F800001. With NAN_EQ=1: ERR_CNT stays 0. With NAN_EQ=0: ERR_CNT=1.
- Reset mid-run: assert RST for 1 cycle while 3 entries are in flight. Required: all outputs 0 immediately (asynchronous), no compares for the flushed entries, the subsequent run counts from 0.
- Empty file / saturation: EOF on the first EN cycle gives CHK_CNT=0, PASS=1, END_SIM after LATENCY cycles. With CNT_W=4, 20 mismatching samples give ERR_CNT=CHK_CNT=15.
